// File: rtl/interlaken_tx_meta_framer_pkg.sv
// Shared constants and state encoding for the Interlaken TX metaframe
// generator and the CRC-32C helper it shares with the RX checker.
package interlaken_tx_meta_framer_pkg;

  localparam logic [64:0] SYNC_WORD   = 65'h1_78f678f678f678f6;
  localparam logic [64:0] SKIP_WORD   = 65'h1_1e1e1e1e1e1e1e1e;
  localparam logic [5:0]  SCRAM_HDR   = 6'b001010;
  localparam logic [5:0]  DIAG_HDR    = 6'b011001;
  localparam logic [31:0] CRC32C_POLY = 32'h1EDC6F41;
  localparam logic [31:0] CRC_SEED    = 32'hFFFFFFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/interlaken_tx_meta_framer_crc32c.sv
// Combinational CRC-32C update over one 64-bit word, MSB (bit 63) first.
module crc32c_dat64
  import interlaken_tx_meta_framer_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // NOTE: blocking '=' is deliberate here; each loop step must see the
  // previous step's value within the same evaluation.
  always_comb begin
    c = crc_in;
    for (int i = 63; i >= 0; i--) begin
      c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CRC32C_POLY : 32'h0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/interlaken_tx_meta_framer.sv
// Interlaken TX lane metaframe generator: wraps payload words with sync,
// scrambler-state, skip and diagnostic words and fills in the lane CRC-32C.
module interlaken_tx_meta_framer
  import interlaken_tx_meta_framer_pkg::*;
#(
  parameter int unsigned META_FRAME_LEN = 10,
  parameter logic [64:0] IDLE_WORD      = 65'h1_0000000000000000
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        enable,
  input  logic        lane_status,
  input  logic        link_status,
  input  logic [57:0] scram_state,
  input  logic [64:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [64:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        frame_start
);

  localparam int CNT_W = $clog2(META_FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_SLOT     = CNT_W'(META_FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FIRST_PAYLOAD = CNT_W'(3);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        crc_q, crc_d;
  logic [64:0]        dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               frame_start_q, frame_start_d;

  logic               is_sync, is_scram, is_skip, is_diag, is_payload, adv;
  logic [64:0]        base_word, tx_word;
  logic [63:0]        crc_data;
  logic [31:0]        crc_in, crc_out;

  assign is_sync    = (cnt_q == '0);
  assign is_scram   = (cnt_q == CNT_W'(1));
  assign is_skip    = (cnt_q == CNT_W'(2));
  assign is_diag    = (cnt_q == LAST_SLOT);
  assign is_payload = (cnt_q >= FIRST_PAYLOAD) && !is_diag;

  // Output register is free when empty or being drained this cycle.
  assign adv       = (state_q == ST_RUN) && (dout_ready || !dout_valid_q);
  assign din_ready = adv && is_payload;

  always_comb begin
    base_word = din_valid ? din : IDLE_WORD;
    if (is_sync)       base_word = SYNC_WORD;
    else if (is_scram) base_word = {1'b1, SCRAM_HDR, scram_state};
    else if (is_skip)  base_word = SKIP_WORD;
    else if (is_diag)  base_word = {1'b1, DIAG_HDR, 24'h0, lane_status, link_status, 32'h0};
  end

  // The CRC covers the scrambler-state word with its state bits zeroed.
  assign crc_data = is_scram ? {SCRAM_HDR, 58'h0} : base_word[63:0];
  assign crc_in   = is_sync ? CRC_SEED : crc_q;
  assign tx_word  = is_diag ? {base_word[64:32], ~crc_out} : base_word;

  crc32c_dat64 u_crc (
    .crc_in  (crc_in),
    .data    (crc_data),
    .crc_out (crc_out)
  );

  // NOTE: every variable gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    crc_d         = crc_q;
    dout_d        = dout_q;
    dout_valid_d  = dout_valid_q;
    frame_start_d = frame_start_q;
    case (state_q)
      ST_IDLE: begin
        // The final diagnostic word may still be waiting to be taken.
        if (dout_ready) begin
          dout_valid_d  = 1'b0;
          frame_start_d = 1'b0;
        end
        if (enable) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (adv) begin
          dout_d        = tx_word;
          dout_valid_d  = 1'b1;
          frame_start_d = is_sync;
          crc_d         = crc_out;
          if (is_diag) begin
            cnt_d = '0;
            if (!enable) state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // together from the values sampled at the edge.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      crc_q         <= CRC_SEED;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      crc_q         <= crc_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_interlaken_tx_meta_framer.sv
// Randomized bench for the TX metaframe generator against a frame-level
// reference model with a long-division CRC-32C.
module tb_interlaken_tx_meta_framer;

  localparam int LEN = 10;
  localparam logic [64:0] SYNC  = 65'h1_78f678f678f678f6;
  localparam logic [64:0] SKIP  = 65'h1_1e1e1e1e1e1e1e1e;
  localparam logic [64:0] IDLEW = 65'h1_0000000000000000;

  logic        clk = 1'b0;
  logic        srst, enable, lane_status, link_status;
  logic [57:0] scram_state;
  logic [64:0] din, dout;
  logic        din_valid, din_ready, dout_valid, dout_ready, frame_start;

  interlaken_tx_meta_framer #(.META_FRAME_LEN(LEN)) dut (
    .clk         (clk),
    .srst        (srst),
    .enable      (enable),
    .lane_status (lane_status),
    .link_status (link_status),
    .scram_state (scram_state),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [64:0] in_q[$];
  logic [64:0] out_log[$];
  bit          fs_log[$];
  logic [63:0] fr[LEN];
  int          pos = 0;
  int          words = 0;
  int          idle_cnt = 0;
  bit          prev_stall = 0;
  logic [64:0] prev_dout;

  // Stimulus knobs
  bit rdy_rand = 0;
  int vld_mode = 0;  // 0 always valid, 1 never, 2 random
  bit data_inc = 1;

  // CRC-32C as polynomial long division of the whole frame bit stream,
  // with the all-ones seed folded into the first 32 message bits.
  function automatic logic [31:0] crc_ref();
    bit          msg[LEN*64+32];
    logic [32:0] p = 33'h1_1EDC6F41;
    logic [31:0] r;
    for (int w = 0; w < LEN; w++)
      for (int b = 63; b >= 0; b--) msg[w*64 + (63-b)] = fr[w][b];
    for (int i = 0; i < 32; i++) msg[i] = ~msg[i];
    for (int i = LEN*64; i < LEN*64+32; i++) msg[i] = 1'b0;
    for (int i = 0; i < LEN*64; i++)
      if (msg[i]) for (int j = 0; j <= 32; j++) msg[i+j] = msg[i+j] ^ p[32-j];
    for (int k = 0; k < 32; k++) r[31-k] = msg[LEN*64+k];
    return r;
  endfunction

  task automatic model_reset();
    in_q.delete();
    out_log.delete();
    fs_log.delete();
    pos = 0;
    prev_stall = 0;
  endtask

  task automatic model_consume(input logic [64:0] w, input logic fs);
    logic [64:0] exp;
    logic [63:0] cw;
    if (pos == 0) begin
      exp = SYNC; cw = exp[63:0];
    end else if (pos == 1) begin
      exp = {1'b1, 6'b001010, scram_state}; cw = {6'b001010, 58'h0};
    end else if (pos == 2) begin
      exp = SKIP; cw = exp[63:0];
    end else if (pos == LEN-1) begin
      cw = {6'b011001, 24'h0, lane_status, link_status, 32'h0};
      fr[pos] = cw;
      exp = {1'b1, cw[63:32], ~crc_ref()};
    end else begin
      if (in_q.size() > 0) exp = in_q.pop_front();
      else begin exp = IDLEW; idle_cnt++; end
      cw = exp[63:0];
    end
    fr[pos] = cw;
    check($sformatf("word_slot%0d", pos), w, exp);
    check($sformatf("frame_start_slot%0d", pos), 65'(fs), 65'(pos == 0));
    out_log.push_back(w);
    fs_log.push_back(fs);
    pos = (pos == LEN-1) ? 0 : pos + 1;
    words++;
  endtask

  task automatic monitor();
    if (prev_stall) begin
      check("stall_dout_stable", dout, prev_dout);
      check("stall_valid_stable", 65'(dout_valid), 65'd1);
    end
    if (dout_valid && !dout_ready) check("din_ready_in_stall", 65'(din_ready), 65'd0);
    if (dout_valid && dout_ready) model_consume(dout, frame_start);
    if (din_valid && din_ready) in_q.push_back(din);
    prev_stall = dout_valid && !dout_ready;
    prev_dout  = dout;
  endtask

  task automatic cycle();
    bit acc_in;
    @(negedge clk);
    acc_in = din_valid && din_ready;
    if (srst) model_reset();
    else monitor();
    @(posedge clk);
    #1;
    if (acc_in) din = data_inc ? din + 65'd1 : {1'b0, 32'($urandom), 32'($urandom)};
    dout_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    din_valid  = (vld_mode == 0) ? 1'b1 : (vld_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
  endtask

  task automatic wait_words(input string tag, input int target, input int budget);
    int start = words;
    int n = 0;
    while ((words - start) < target && n < budget) begin cycle(); n++; end
    check(tag, 65'(words - start), 65'(target));
  endtask

  task automatic wait_pos(input string tag, input int p);
    int n = 0;
    while (pos != p && n < 500) begin cycle(); n++; end
    check(tag, 65'(pos), 65'(p));
  endtask

  task automatic do_reset();
    srst = 1'b1; dout_ready = 1'b0; din_valid = 1'b0;
    cycle();
    srst = 1'b0;
  endtask

  task automatic sync_latency(input string tag);
    int n = 0;
    while (!dout_valid && n < 10) begin cycle(); n++; end
    check(tag, 65'(n), 65'd2);
    check({tag, "_dout"}, dout, SYNC);
    check({tag, "_fs"}, 65'(frame_start), 65'd1);
  endtask

  initial begin
    logic [9:0] fsv;
    int idle0;
    srst = 1'b1; enable = 1'b0; lane_status = 1'b0; link_status = 1'b1;
    scram_state = 58'({$urandom, $urandom});
    din = 65'd1; din_valid = 1'b0; dout_ready = 1'b0;
    repeat (3) cycle();
    check("rst_dout", dout, 65'h0);
    check("rst_dout_valid", 65'(dout_valid), 65'd0);
    check("rst_frame_start", 65'(frame_start), 65'd0);
    check("rst_din_ready", 65'(din_ready), 65'd0);

    // Incrementing payload, no backpressure
    srst = 1'b0; enable = 1'b1;
    sync_latency("t1_sync_latency");
    wait_words("t1_words", 2*LEN + 4, 200);
    check("t1_sync", out_log[0], SYNC);
    check("t1_skip", out_log[2], SKIP);
    for (int i = 0; i < LEN-4; i++) check($sformatf("t1_payload%0d", i), out_log[3+i], 65'(i+1));
    check("t1_frame2_payload", out_log[LEN+3], 65'(LEN-3));
    for (int i = 0; i < 10; i++) fsv[i] = fs_log[i];
    check("t1_frame_start_map", 65'(fsv), 65'h001);

    // No payload offered: every payload slot carries the idle word
    vld_mode = 1;
    do_reset();
    idle0 = idle_cnt;
    wait_words("t2_words", 2*LEN, 200);
    check("t2_idle_slots", 65'(idle_cnt - idle0), 65'(2*(LEN-4)));

    // Random backpressure and random payload for three metaframes
    vld_mode = 2; data_inc = 1'b0; rdy_rand = 1'b1;
    wait_words("t3_words", 3*LEN, 2000);

    // Drop enable mid-frame; the frame completes, then the lane idles
    rdy_rand = 1'b0;
    wait_pos("t4_reach_slot4", 4);
    enable = 1'b0;
    repeat (40) cycle();
    check("t4_frame_completed", 65'(pos), 65'd0);
    check("t4_idle_valid", 65'(dout_valid), 65'd0);
    enable = 1'b1;
    sync_latency("t4_resync_latency");

    // Synchronous reset mid-frame, then a fresh frame with reseeded CRC
    rdy_rand = 1'b1;
    wait_pos("t5_reach_slot6", 6);
    srst = 1'b1; dout_ready = 1'b0; din_valid = 1'b0;
    cycle();
    check("t5_srst_valid", 65'(dout_valid), 65'd0);
    check("t5_srst_dout", dout, 65'h0);
    srst = 1'b0;
    wait_words("t5_words", 2*LEN, 600);

    // Fixed status and scrambler pattern
    lane_status = 1'b1; link_status = 1'b0; scram_state = 58'h2AAAAAAAAAAAAAA;
    rdy_rand = 1'b0;
    do_reset();
    wait_words("t6_words", LEN, 200);
    check("t6_scram_word", out_log[1], 65'h1_2AAAAAAAAAAAAAAA);
    check("t6_diag_status", 65'(out_log[LEN-1][33:32]), 65'd2);

    // Drain: nothing accepted may be left unsent
    enable = 1'b0; vld_mode = 1;
    repeat (60) cycle();
    check("drain_in_queue", 65'(in_q.size()), 65'd0);
    check("drain_valid", 65'(dout_valid), 65'd0);
    check("drain_frame_boundary", 65'(pos), 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
